alu_result_serializer: RTL
==========================

Name: alu_result_serializer

Overview:
- Downstream stage of the ALU's registered result outputs (arithmetic, logic, compare and shift units).
- Captures each one-cycle-valid ALU result into a 2-entry buffer and splits it into bytes, LSB first.
- Presents the bytes to the UART TX path over a valid/ready handshake.
- Decouples single-cycle ALU result pulses from the much slower UART byte rate.

Parameters:
- ALU_WIDTH, 16, width of the ALU result; must be a multiple of 8 and at least 8.
- NUM_BYTES, ALU_WIDTH/8, derived local constant; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- alu_out  input  ALU_WIDTH  registered ALU result.
- alu_out_valid  input  1  one-cycle pulse; alu_out is valid in the same cycle.
- tx_ready  input  1  UART TX accepts a byte at the edge where tx_valid and tx_ready are both high.
- clr_ovf  input  1  synchronous clear of ovf.
- tx_data  output  8  byte currently offered.
- tx_valid  output  1  tx_data is valid.
- busy  output  1  high when the buffer is non-empty or a result is being sent.
- ovf  output  1  sticky flag: a result was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx_data=0, tx_valid=0, busy=0, ovf=0.
  - Buffer count=0, byte index=0, state=IDLE.
  - Reset asserted mid-transfer discards all buffered and partially sent results. No byte is re-sent after reset.
- Buffer (2-entry FIFO, count 0..2):
  - Push on any edge with alu_out_valid=1.
  - Pop when the FSM loads its shift register.
  - Push and pop on the same edge: count is unchanged and both operations succeed, including when count=2.
  - Push with count=2 and no pop on that edge: result dropped, ovf<=1, count stays 2.
- ovf:
  - Set by a dropped push.
  - Cleared by clr_ovf=1 at an edge.
  - A drop and clr_ovf on the same edge leave ovf=1 (set wins).
- FSM states: IDLE, SEND.
  - IDLE: tx_valid=0. If count>0 at an edge, pop the head into the shift register, set idx=0, go to SEND.
  - A result pushed at edge k is popped at edge k+1. tx_valid is first high after edge k+1.
  - SEND: tx_valid=1 and tx_data=shift[7:0]. tx_data is stable while tx_valid=1 and tx_ready=0.
  - On a transfer with idx<NUM_BYTES-1: shift right by 8, idx+1.
  - On a transfer with idx=NUM_BYTES-1 and count>0: pop the next result, idx=0, stay in SEND. tx_valid stays high with no bubble.
  - On a transfer with idx=NUM_BYTES-1 and count=0: go to IDLE; tx_valid=0 after the edge.
  - tx_ready while tx_valid=0 has no effect.
- NUM_BYTES=1: every transfer completes a result.
- busy = (state==SEND) or (count!=0), combinational from registers.
- Throughput: one byte per transfer edge; no idle cycle between consecutive results.

Decomposition:
- Shared package:
  - ALU_WIDTH default
  - byte width constant 8
  - FSM state encoding (IDLE=1'b0, SEND=1'b1)
- Sub-module result_fifo:
  - 2-entry, ALU_WIDTH wide, push/pop/count/full/empty.
  - Handles simultaneous push and pop when full.
  - Does not own the overflow flag.
- The serializer FSM, shift register, byte index and ovf logic live in the top module.

Test Plan:
- Reset mid-SEND (first byte of 0xBEEF sent, rst_n pulsed low) -> all outputs 0 immediately. After release, no bytes appear until a new alu_out_valid.
- Single result, tx_ready tied 1, alu_out=0xA55A pulsed at edge k -> tx_valid high after edge k+1. Bytes 0x5A then 0xA5 on consecutive edges. tx_valid=0 after the second transfer; busy falls with it.
- Backpressure: alu_out=0x1234, tx_ready=0 for 5 cycles then 1 -> tx_data holds 0x34 stable for all 5 cycles, then 0x34 and 0x12 transfer.
- Back-to-back pulses 0x1111, 0x2222, 0x3333 on 3 consecutive edges with tx_ready=0 -> count reaches 2 and ovf=0 (the first result has already been popped into the shift register). Release tx_ready -> bytes 11,11,22,22,33,33 with tx_valid continuously high.
- Overflow: with tx_ready=0, pulse 4 results (0x0001..0x0004) -> 0x0004 dropped, ovf=1. Release tx_ready -> only results 1..3 are emitted. Then clr_ovf=1 -> ovf=0 next cycle.
- Full buffer with push and pop on the same edge (last byte of the in-flight result transfers as 0x5555 is pushed) -> 0x5555 accepted, ovf stays 0, count stays 2.

Source files
------------

// File: rtl/alu_result_serializer_pkg.sv
// Shared constants and FSM encoding for the ALU result serializer.
// Imported by the result FIFO and the serializer top.
package alu_result_serializer_pkg;

   localparam int ALU_WIDTH_DEFAULT = 16;
   localparam int BYTE_W            = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/alu_result_serializer_fifo.sv
// Two-entry result buffer between the ALU and the byte serializer.
// A push into a full buffer is only accepted when a pop happens on the same edge.
module result_fifo
   import alu_result_serializer_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // When full, wr_ptr equals rd_ptr: a simultaneous push overwrites the slot being popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers one-cycle ALU results and streams them out LSB byte first
// over a valid/ready handshake towards the UART transmitter.
module alu_result_serializer
   import alu_result_serializer_pkg::*;
#(
   parameter int ALU_WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ALU_WIDTH-1:0] alu_out,
   input  logic                 alu_out_valid,
   input  logic                 tx_ready,
   input  logic                 clr_ovf,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   output logic                 busy,
   output logic                 ovf
);

   localparam int NUM_BYTES = ALU_WIDTH / BYTE_W;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   if (ALU_WIDTH < BYTE_W || (ALU_WIDTH % BYTE_W) != 0) begin : g_bad_width
      $error("ALU_WIDTH must be a non-zero multiple of 8");
   end

   state_t               state;
   state_t               state_next;
   logic [ALU_WIDTH-1:0] shift;
   logic [ALU_WIDTH-1:0] shift_next;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_next;
   logic                 pop;
   logic [ALU_WIDTH-1:0] head;
   logic [1:0]           count;
   logic                 full;
   logic                 empty;
   logic                 drop;

   result_fifo #(
      .WIDTH (ALU_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (alu_out_valid),
      .din   (alu_out),
      .pop   (pop),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Loading the next result on the final transfer keeps tx_valid high with no bubble.
   always_comb begin
      state_next = state;
      shift_next = shift;
      idx_next   = idx;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_next = head;
               idx_next   = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               if (idx != LAST_IDX) begin
                  shift_next = shift >> BYTE_W;
                  idx_next   = idx + IDX_W'(1);
               end else if (!empty) begin
                  pop        = 1'b1;
                  shift_next = head;
                  idx_next   = '0;
               end else begin
                  idx_next   = '0;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         shift <= '0;
         idx   <= '0;
      end else begin
         state <= state_next;
         shift <= shift_next;
         idx   <= idx_next;
      end
   end

   // A dropped result beats a simultaneous clear so no overflow event is lost.
   assign drop = alu_out_valid && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

   assign tx_valid = (state == SEND);
   assign tx_data  = (state == SEND) ? shift[7:0] : 8'h00;
   assign busy     = (state == SEND) || (count != 2'd0);

endmodule
